// File: rtl/image_write.sv
// image_write: writes a framed multi-lane pixel stream into linear image memory from a base address
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  input  logic                          image_last,
  input  logic                          image_val,
  output logic                          image_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state;
  logic [15:0] img_w, img_h, img_d, w_cnt, h_cnt, d_cnt;
  logic [MEM_AWIDTH-1:0] base, addr_cnt;
  logic beat, w_last, h_last, last;
  assign beat   = image_val & image_rdy;
  assign w_last = w_cnt == img_w;
  assign h_last = h_cnt == img_h;
  assign last   = w_last & h_last & (d_cnt == img_d);
  // size and base registers; only writable while idle so a running image keeps its geometry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_w <= '0;
      img_h <= '0;
      img_d <= '0;
      base  <= '0;
    end else if (cfg_valid && state == IDLE) begin
      if (cfg_addr == CFG_AWIDTH'(8)) img_w <= cfg_data[15:0];
      if (cfg_addr == CFG_AWIDTH'(9)) {img_d, img_h} <= cfg_data[31:0];
      if (cfg_addr == CFG_AWIDTH'(10)) base <= cfg_data[MEM_AWIDTH-1:0];
    end
  end
  // control FSM with dimension counters, framing check and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_cnt     <= '0;
      h_cnt     <= '0;
      d_cnt     <= '0;
      addr_cnt  <= '0;
      image_rdy <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_val    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_val <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (next) begin
          state     <= WRITE;
          w_cnt     <= '0;
          h_cnt     <= '0;
          d_cnt     <= '0;
          addr_cnt  <= base;
          err       <= 1'b0;
          image_rdy <= 1'b1;
          busy      <= 1'b1;
        end
        WRITE: if (beat) begin
          wr_val   <= 1'b1;
          wr_addr  <= addr_cnt;
          wr_data  <= image_bus;
          addr_cnt <= addr_cnt + 1'b1;
          w_cnt    <= w_last ? '0 : w_cnt + 1'b1;
          if (w_last) h_cnt <= h_last ? '0 : h_cnt + 1'b1;
          if (w_last && h_last) d_cnt <= d_cnt + 1'b1;
          if (image_last != last) err <= 1'b1;
          if (last) begin
            state     <= DONE;
            image_rdy <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_write.sv
// tb_image_write: directed scenarios against a queue-based model of the expected memory writes
module tb_image_write;
  logic        clk = 0, rst_n = 0;
  logic [31:0] cfg_data = 0;
  logic [4:0]  cfg_addr = 0;
  logic        cfg_valid = 0, next = 0;
  logic [63:0] image_bus = 0;
  logic        image_last = 0, image_val = 0;
  logic        image_rdy, wr_val, busy, done, err;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;

  image_write dut (
    .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .next(next), .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
    .image_rdy(image_rdy), .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] a; logic [63:0] d; bit l;} exp_t;
  exp_t expq[$];
  logic [15:0] seen[$];
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pix(input int i);
    return {16'(i), ~16'(i), 16'(i * 7 + 3), 16'(i)};
  endfunction

  // every write must match the next planned beat, and done must coincide with the final one
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    bit exp_done;
    exp_done = 0;
    if (wr_val) begin
      if (expq.size() == 0) chk("spurious_write", 1, 0);
      else begin
        e = expq.pop_front();
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
        exp_done = e.l;
        seen.push_back(wr_addr);
      end
    end
    chk("done", done, exp_done);
  end

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_valid = 1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic setup(input logic [15:0] w, input logic [15:0] d, input logic [15:0] h, input logic [15:0] b);
    cfg_wr(5'd8, {16'd0, w});
    cfg_wr(5'd9, {d, h});
    cfg_wr(5'd10, {16'd0, b});
  endtask

  // arm one image and stream n beats; optional extra last, stalls, lockout attempt or reset abort
  task automatic run_image(input int n, input logic [15:0] b, input bit stall, input int last_at,
                           input int lock_at, input int reset_at);
    int i, cyc;
    bit tog, acc, fin, exp_err;
    i = 0; cyc = 0; tog = 0; exp_err = 0;
    seen.delete();
    @(negedge clk); next = 1;
    @(negedge clk); next = 0;
    while (i < n) begin
      if (i == reset_at) begin
        #2 rst_n = 0;
        #1;
        chk("rst_wr_val", wr_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", image_rdy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        expq.delete();
        image_val = 1;
        repeat (10) begin
          @(negedge clk);
          chk("post_rst_rdy", image_rdy, 0);
          chk("post_rst_busy", busy, 0);
        end
        image_val = 0;
        return;
      end
      image_val = stall ? tog : 1'b1;
      tog = !tog;
      fin = (i == n - 1);
      image_bus = pix(i);
      image_last = fin || (i == last_at);
      if (i == lock_at) begin
        cfg_valid = 1; cfg_addr = 5'd10; cfg_data = 32'h2000; next = 1;
      end
      chk("rdy_in_write", image_rdy, 1);
      acc = image_val;
      if (acc) expq.push_back('{a: b + 16'(i), d: pix(i), l: fin});
      @(negedge clk);
      cfg_valid = 0; next = 0;
      if (acc) begin
        exp_err |= (image_last != fin);
        i++;
      end
      chk("err", err, exp_err);
      if (++cyc > 3 * n + 10) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    image_val = 0; image_last = 0;
    chk("busy_done", busy, 1);
    chk("rdy_done", image_rdy, 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("err_idle", err, exp_err);
    chk("rdy_idle", image_rdy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rdy", image_rdy, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_val", wr_val, 0);
    chk("reset_err", err, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    rst_n = 1;
    // nominal 10x5x8 image
    setup(16'd9, 16'd7, 16'd4, 16'h0100);
    run_image(400, 16'h0100, 0, -1, -1, -1);
    chk("nom_count", seen.size(), 400);
    chk("nom_first", seen[0], 16'h0100);
    chk("nom_last", seen[399], 16'h028F);
    // stalled stream
    run_image(400, 16'h0100, 1, -1, -1, -1);
    chk("stall_count", seen.size(), 400);
    chk("stall_last", seen[399], 16'h028F);
    // busy lockout: base write and next mid-transfer are ignored
    run_image(400, 16'h0100, 0, -1, 100, -1);
    chk("lock_last", seen[399], 16'h028F);
    run_image(400, 16'h0100, 0, -1, -1, -1);
    chk("lock_rearm_first", seen[0], 16'h0100);
    // framing error: last on both beats of a 2-beat image
    setup(16'd1, 16'd0, 16'd0, 16'h0000);
    run_image(2, 16'h0000, 0, 0, -1, -1);
    chk("frame_count", seen.size(), 2);
    chk("frame_a1", seen[1], 16'h0001);
    // address wrap; arming also clears the error left above
    setup(16'd3, 16'd0, 16'd0, 16'hFFFE);
    run_image(4, 16'hFFFE, 0, -1, -1, -1);
    chk("wrap_a0", seen[0], 16'hFFFE);
    chk("wrap_a1", seen[1], 16'hFFFF);
    chk("wrap_a2", seen[2], 16'h0000);
    chk("wrap_a3", seen[3], 16'h0001);
    // reset after 50 beats, with an error already flagged
    setup(16'd9, 16'd7, 16'd4, 16'h0100);
    run_image(400, 16'h0100, 0, 10, -1, 50);
    setup(16'd1, 16'd0, 16'd0, 16'h0040);
    run_image(2, 16'h0040, 0, -1, -1, -1);
    chk("post_rst_a0", seen[0], 16'h0040);
    repeat (3) @(negedge clk);
    chk("leftover_writes", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_write.md
Name: image_write

Overview:
- Stream-to-memory stage that sits upstream of image_read.
- Accepts the layer-output pixel stream as GROUP_NB lanes of IMG_WIDTH and writes it into the image memory that image_read later fetches.
- Generates linear write addresses from base + (d, h, w) counters, checks stream framing against the configured size, and signals completion per image.

Parameters:
CFG_DWIDTH, 32, config data bus width
CFG_AWIDTH, 5, config address width
GROUP_NB, 4, pixel lanes per beat
IMG_WIDTH, 16, bits per pixel lane
MEM_AWIDTH, 16, image memory address width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_data  in  CFG_DWIDTH  config write data
cfg_addr  in  CFG_AWIDTH  config register address
cfg_valid  in  1  config write strobe
next  in  1  single-cycle pulse that arms one image write
image_bus  in  GROUP_NB*IMG_WIDTH  incoming pixel beat
image_last  in  1  marks final beat of image
image_val  in  1  beat valid
image_rdy  out  1  beat accepted when val & rdy
wr_val  out  1  memory write enable
wr_addr  out  MEM_AWIDTH  memory write address
wr_data  out  GROUP_NB*IMG_WIDTH  memory write data
busy  out  1  high from accepted next until done
done  out  1  one-cycle pulse after final write
err  out  1  sticky framing error; cleared on accepted next

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). On reset, all config registers, counters and outputs go to 0, and the state goes to IDLE.
- Config registers, written when cfg_valid is high and state is IDLE; ignored otherwise:
  - CFG_IW_IMG_W = 5'd8: img_w = cfg_data[15:0] (width-1).
  - CFG_IW_IMG_DH = 5'd9: img_d = [31:16] (depth_groups-1), img_h = [15:0] (height-1).
  - CFG_IW_BASE = 5'd10: base = [MEM_AWIDTH-1:0].
  - Any other address is ignored.
- States: IDLE, WRITE, DONE.
- IDLE:
  - image_rdy=0, busy=0.
  - next=1 → WRITE; load w_cnt=h_cnt=d_cnt=0 and addr_cnt=base; clear err.
- WRITE:
  - image_rdy=1, busy=1.
  - Each accepted beat (image_val & image_rdy) increments w_cnt. On w_cnt==img_w, w_cnt wraps to 0 and h_cnt increments. On h_cnt==img_h, h_cnt wraps to 0 and d_cnt increments.
  - addr_cnt increments by 1 per beat, mod 2^MEM_AWIDTH, wrapping silently.
  - Final beat (w, h and d counters all at last) → DONE.
  - next is ignored in WRITE.
- DONE: done=1 for exactly one cycle, busy=1, image_rdy=0; then → IDLE.
- Write port:
  - Registered with 1-cycle latency: the cycle after an accepted beat, wr_val=1, wr_addr=addr_cnt value at acceptance, wr_data=image_bus at acceptance.
  - wr_val=0 in all other cycles; wr_addr/wr_data hold their last value.
  - The final write occurs in the same cycle as done=1.
- Beat count: total = (img_w+1)*(img_h+1)*(img_d+1). Gaps in image_val stall the counters with no writes.
- Framing check:
  - image_last=1 on a non-final beat sets err. Counting continues; image_last does not terminate.
  - image_last=0 on the final beat sets err.
  - err holds until the next accepted next.
- next pulse that coincides with a cfg write in IDLE: the cfg write takes effect and the arm uses the old value of that register.
- rst_n asserted mid-image: immediate return to IDLE, no further writes, err cleared, config lost.

Test Plan:
1. Nominal transfer:
   - Stimulus: cfg W=9, DH={16'd7,16'd4}, BASE=16'h0100; pulse next; drive 400 beats back-to-back, image_bus=beat index, image_last on beat 399.
   - Response: wr_addr 16'h0100..16'h028F in order, wr_data=index; done one cycle with final write; busy low afterwards; err=0.
2. Stalled stream:
   - Stimulus: same config as scenario 1; image_val toggles every other cycle.
   - Response: still exactly 400 writes with identical address/data; writes land only after valid beats; done cycle count roughly doubles.
3. Framing error:
   - Stimulus: W=1, DH={0,0} (2 beats), BASE=0; image_last on beat 0 and on beat 1.
   - Response: err=1 after beat 0; 2 writes to addresses 0,1; done still pulses; next re-arm clears err.
4. Busy lockout:
   - Stimulus: mid-transfer, write BASE=16'h2000 and pulse next.
   - Response: addresses continue from the original base; no restart; after done, a new next uses the old base (the write was ignored).
5. Address wrap:
   - Stimulus: BASE=16'hFFFE, W=3, DH={0,0}.
   - Response: wr_addr sequence FFFE, FFFF, 0000, 0001.
6. Reset mid-operation:
   - Stimulus: deassert rst_n after 50 of 400 beats.
   - Response: wr_val, busy, done, err and image_rdy all go to 0 immediately; no writes after release until config is rewritten and next is pulsed.
